// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store/load request side plus the
// data-memory write-port side. The master modport is the pipeline/memory
// environment; the slave modport is the buffer itself.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    // store request from MEM stage
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_byte;
    logic          st_half;
    logic [31:0]   st_pc;
    logic          st_err;

    // load hazard check
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_stall;

    // data memory write port
    logic          dm_ready;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_byte;
    logic          dm_half;
    logic [31:0]   dm_pc;

    // occupancy
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, st_byte, st_half, st_pc,
        input  st_ready, st_err,
        output ld_valid, ld_addr,
        input  ld_stall,
        output dm_ready,
        input  dm_we, dm_addr, dm_wdata, dm_byte, dm_half, dm_pc,
        input  count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_byte, st_half, st_pc,
        output st_ready, st_err,
        input  ld_valid, ld_addr,
        output ld_stall,
        input  dm_ready,
        output dm_we, dm_addr, dm_wdata, dm_byte, dm_half, dm_pc,
        output count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM-stage store path and the data memory
// write port. Stores drain strictly in order whenever dm_ready is high; a
// load whose word matches any pending store is stalled so it never reads
// stale memory. Entry payload is not reset; only pointers/count/err are.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Entry payload storage (no reset: validity comes from the pointers)
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic          byte_q [DEPTH];
    logic          half_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    // Control state
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          err;

    logic full;
    logic accept;
    logic push;
    logic pop;
    logic stall;

    // Byte stores are always aligned; halves need addr[0]==0, words addr[1:0]==0.
    function automatic logic is_aligned(input logic [AW-1:0] a,
                                        input logic is_b, input logic is_h);
        if (is_b)
            return 1'b1;
        else if (is_h)
            return (a[0] == 1'b0);
        else
            return (a[1:0] == 2'b00);
    endfunction

    // Word-granular compare; shifting keeps every address bit in the expression.
    function automatic logic word_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    // An entry is occupied when its distance from the head is below the count.
    function automatic logic is_occupied(input logic [PW-1:0] idx,
                                         input logic [PW-1:0] head,
                                         input logic [CW-1:0] n);
        logic [PW-1:0] off;
        off = idx - head;
        return CW'(off) < n;
    endfunction

    assign full   = (cnt == CW'(DEPTH));
    assign accept = bus.st_valid & ~full;
    assign push   = accept & is_aligned(bus.st_addr, bus.st_byte, bus.st_half);
    assign pop    = (cnt != '0) & bus.dm_ready;

    assign bus.st_ready = ~full;
    assign bus.st_err   = err;
    assign bus.count    = cnt;

    assign bus.dm_we    = (cnt != '0);
    assign bus.dm_addr  = addr_q[rd_ptr];
    assign bus.dm_wdata = data_q[rd_ptr];
    assign bus.dm_byte  = byte_q[rd_ptr];
    assign bus.dm_half  = half_q[rd_ptr];
    assign bus.dm_pc    = pc_q[rd_ptr];

    // Pointers, occupancy and the one-cycle misalignment pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            err <= accept & ~push;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Capture an aligned store at the tail; half flag is meaningless for bytes
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.st_addr;
            data_q[wr_ptr] <= bus.st_data;
            byte_q[wr_ptr] <= bus.st_byte;
            half_q[wr_ptr] <= bus.st_half & ~bus.st_byte;
            pc_q[wr_ptr]   <= bus.st_pc;
        end
    end

    // Any occupied entry in the same word as the load blocks it, including
    // the head that may be popping this cycle.
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (is_occupied(PW'(i), rd_ptr, cnt) && word_match(addr_q[i], bus.ld_addr))
                stall = 1'b1;
        end
    end

    assign bus.ld_stall = bus.ld_valid & stall;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    store_buffer_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) sbi ();

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        b;
        logic        h;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    logic err_exp;
    logic last_accept;
    int   tests;
    int   fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic aligned_ok(input logic [31:0] a, input logic b, input logic h);
        if (b) return 1'b1;
        if (h) return a[0] == 1'b0;
        return a % 4 == 0;
    endfunction

    task automatic model_clear();
        q.delete();
        err_exp     = 1'b0;
        last_accept = 1'b0;
    endtask

    // Compare every output against the model at the falling edge.
    task automatic sample();
        logic st_exp;
        @(negedge clk);
        chk("count", 64'(sbi.count), 64'(q.size()));
        chk("st_ready", 64'(sbi.st_ready), 64'(q.size() < DEPTH));
        chk("dm_we", 64'(sbi.dm_we), 64'(q.size() != 0));
        chk("st_err", 64'(sbi.st_err), 64'(err_exp));
        if (q.size() != 0) begin
            chk("dm_addr", 64'(sbi.dm_addr), 64'(q[0].addr));
            chk("dm_wdata", 64'(sbi.dm_wdata), 64'(q[0].data));
            chk("dm_byte", 64'(sbi.dm_byte), 64'(q[0].b));
            chk("dm_half", 64'(sbi.dm_half), 64'(q[0].h));
            chk("dm_pc", 64'(sbi.dm_pc), 64'(q[0].pc));
        end
        st_exp = 1'b0;
        if (sbi.ld_valid)
            foreach (q[k])
                if ((q[k].addr >> 2) == (sbi.ld_addr >> 2)) st_exp = 1'b1;
        chk("ld_stall", 64'(sbi.ld_stall), 64'(st_exp));
    endtask

    // Apply one rising edge to the model with the inputs currently driven.
    task automatic advance();
        logic acc, ok, pop;
        ent_t e;
        acc = sbi.st_valid && (q.size() < DEPTH);
        ok  = aligned_ok(sbi.st_addr, sbi.st_byte, sbi.st_half);
        pop = (q.size() != 0) && sbi.dm_ready;
        e.addr = sbi.st_addr;
        e.data = sbi.st_data;
        e.b    = sbi.st_byte;
        e.h    = sbi.st_half && !sbi.st_byte;
        e.pc   = sbi.st_pc;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc && ok) q.push_back(e);
        err_exp     = acc && !ok;
        last_accept = acc;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                            input logic b, input logic h, input logic [31:0] pc);
        sbi.st_valid = v;
        sbi.st_addr  = a;
        sbi.st_data  = d;
        sbi.st_byte  = b;
        sbi.st_half  = h;
        sbi.st_pc    = pc;
    endtask

    logic [31:0] exp_addr [5];

    initial begin
        tests = 0;
        fails = 0;
        model_clear();
        reset = 1'b0;
        drive_st(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        sbi.ld_valid = 1'b0;
        sbi.ld_addr  = 32'h0;
        sbi.dm_ready = 1'b0;

        // Reset held two cycles, then released
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
        sample();
        chk("rst_count", 64'(sbi.count), 64'd0);
        chk("rst_st_ready", 64'(sbi.st_ready), 64'd1);
        advance();

        // Single word store drains on the next cycle
        sbi.dm_ready = 1'b1;
        drive_st(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h3000);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        sample();
        chk("sw_dm_we", 64'(sbi.dm_we), 64'd1);
        chk("sw_dm_addr", 64'(sbi.dm_addr), 64'h10);
        chk("sw_dm_pc", 64'(sbi.dm_pc), 64'h3000);
        advance();
        sample();
        chk("sw_drained", 64'(sbi.count), 64'd0);
        advance();

        // Fill to full, hold a fifth store, then drain with wrap
        sbi.dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 32'(4 * i), 32'(100 + i), 1'b0, 1'b0, 32'(32'h4000 + 4 * i));
            cyc();
        end
        drive_st(1'b1, 32'h10, 32'h55, 1'b0, 1'b0, 32'h4010);
        sample();
        chk("full_count", 64'(sbi.count), 64'd4);
        chk("full_ready", 64'(sbi.st_ready), 64'd0);
        advance();
        sbi.dm_ready = 1'b1;
        exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8;
        exp_addr[3] = 32'hC; exp_addr[4] = 32'h10;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("drain_order", 64'(sbi.dm_addr), 64'(exp_addr[i]));
            advance();
            if (last_accept) sbi.st_valid = 1'b0;
        end
        sample();
        chk("drain_empty", 64'(sbi.count), 64'd0);
        advance();

        // Byte store stalls a load to the same word only
        sbi.dm_ready = 1'b0;
        drive_st(1'b1, 32'h23, 32'hAB, 1'b1, 1'b0, 32'h5000);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        sbi.ld_valid = 1'b1;
        sbi.ld_addr  = 32'h20;
        sample();
        chk("ld_same_word", 64'(sbi.ld_stall), 64'd1);
        advance();
        sbi.ld_addr = 32'h24;
        sample();
        chk("ld_next_word", 64'(sbi.ld_stall), 64'd0);
        advance();
        sbi.ld_addr  = 32'h20;
        sbi.dm_ready = 1'b1;
        sample();
        chk("sb_dm_byte", 64'(sbi.dm_byte), 64'd1);
        chk("sb_pop_stall", 64'(sbi.ld_stall), 64'd1);
        advance();
        sbi.dm_ready = 1'b0;
        sample();
        chk("ld_after_drain", 64'(sbi.ld_stall), 64'd0);
        advance();
        sbi.ld_valid = 1'b0;

        // Misaligned half is dropped with a one-cycle error pulse
        drive_st(1'b1, 32'h11, 32'h1234, 1'b0, 1'b1, 32'h6000);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        sample();
        chk("mis_err", 64'(sbi.st_err), 64'd1);
        chk("mis_count", 64'(sbi.count), 64'd0);
        chk("mis_dm_we", 64'(sbi.dm_we), 64'd0);
        advance();
        sample();
        chk("mis_err_clr", 64'(sbi.st_err), 64'd0);
        advance();
        drive_st(1'b1, 32'h12, 32'h1234, 1'b0, 1'b1, 32'h6004);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        sample();
        chk("sh_dm_half", 64'(sbi.dm_half), 64'd1);
        chk("sh_dm_wdata", 64'(sbi.dm_wdata), 64'h1234);
        advance();
        sbi.dm_ready = 1'b1;
        cyc();

        // Simultaneous enqueue and pop with two entries pending
        sbi.dm_ready = 1'b0;
        drive_st(1'b1, 32'h40, 32'h1, 1'b0, 1'b0, 32'h7000);
        cyc();
        drive_st(1'b1, 32'h44, 32'h2, 1'b0, 1'b0, 32'h7004);
        cyc();
        sbi.dm_ready = 1'b1;
        drive_st(1'b1, 32'h48, 32'h3, 1'b0, 1'b0, 32'h7008);
        sample();
        chk("both_count_pre", 64'(sbi.count), 64'd2);
        chk("both_head_pre", 64'(sbi.dm_addr), 64'h40);
        advance();
        drive_st(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        sbi.dm_ready = 1'b0;
        sample();
        chk("both_count_post", 64'(sbi.count), 64'd2);
        chk("both_head_post", 64'(sbi.dm_addr), 64'h44);
        advance();

        // Asynchronous reset in the middle of a fill
        drive_st(1'b1, 32'h80, 32'h9, 1'b0, 1'b0, 32'h8000);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("async_count", 64'(sbi.count), 64'd0);
        chk("async_dm_we", 64'(sbi.dm_we), 64'd0);
        chk("async_ready", 64'(sbi.st_ready), 64'd1);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
        cyc();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            drive_st(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                     sel == 0, sel == 1, $urandom);
            sbi.dm_ready = ($urandom_range(0, 2) != 0);
            sbi.ld_valid = 1'($urandom_range(0, 1));
            sbi.ld_addr  = 32'($urandom_range(0, 63));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
